serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_single
//  Description : One-bit full adder cell used as the serial adder's ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_single (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    // Sum and carry of a single bit position
    always_comb begin
        S    = A ^ B ^ Cin;
        Cout = (A & B) | (A & Cin) | (B & Cin);
    end

endmodule

// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder. Latches two WIDTH-bit operands and a
//                carry-in, adds them LSB-first through one full-adder cell
//                (one bit per clock) and presents a registered sum with a
//                busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    // Counter only needs to reach WIDTH-1
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_accept;
    logic             w_last;

    // Start is only honoured outside RUN; in RUN it is ignored entirely
    assign w_accept = (r_state != ST_RUN) && start;
    assign w_last   = (r_cnt == c_LAST_BIT);

    full_adder_single u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_fa_s),
        .Cout (w_fa_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-decoded handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting, carry hold and result registration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_s      <= '0;
            r_cout   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_sum_sh <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry  <= w_fa_c;
            r_cnt    <= r_cnt + 1'b1;
            // The final bit goes straight into the result; S/Cout move only here
            if (w_last) begin
                r_s    <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
                r_cout <= w_fa_c;
            end
        end else if (w_accept) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands with start for one edge; returns at the first sample
    // point after the accepting edge (cycle k=1) with start dropped.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
        A     = a;
        B     = b;
        Cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample n cycles starting at the current sample point (k=1..n)
    task automatic observe(input int n, output int busy_n, output int busy_last,
                           output int done_n, output int done_k);
        busy_n = 0; busy_last = 0; done_n = 0; done_k = 0;
        for (int k = 1; k <= n; k++) begin
            if (busy) begin busy_n++; busy_last = k; end
            if (done) begin done_n++; if (done_k == 0) done_k = k; end
            if (k < n) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_hs: busy,done=%b required 00", {busy, done}); else pass_cnt++;
        total_cnt++; if ({Cout, S} !== 9'h000) $display("FAIL reset_res: Cout,S=%h required 000", {Cout, S}); else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL idle_hold: busy,done=%b required 00", {busy, done}); else pass_cnt++;
    endtask

    task automatic test_basic();
        int bn, bl, dn, dk;
        launch(8'h05, 8'h03, 1'b0);
        observe(12, bn, bl, dn, dk);
        total_cnt++; if (bn !== 8 || bl !== 8) $display("FAIL basic_busy: cycles=%0d last=%0d required 8/8", bn, bl); else pass_cnt++;
        total_cnt++; if (dn !== 1 || dk !== 9) $display("FAIL basic_done: count=%0d at=%0d required 1 at 9", dn, dk); else pass_cnt++;
        total_cnt++; if ({Cout, S} !== 9'h008) $display("FAIL basic_sum: Cout,S=%h required 008", {Cout, S}); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_carry_ripple();
        int bn, bl, dn, dk;
        launch(8'hFF, 8'h01, 1'b0);
        observe(12, bn, bl, dn, dk);
        total_cnt++; if ({Cout, S} !== 9'h100) $display("FAIL ripple_sum: Cout,S=%h required 100", {Cout, S}); else pass_cnt++;
        total_cnt++; if (dn !== 1) $display("FAIL ripple_done: count=%0d required 1", dn); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int bn = 0, dn = 0, dk = 0;
        launch(8'hFF, 8'hFF, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (busy) bn++;
            if (done) begin dn++; if (dk == 0) dk = k; end
            if (k == 3) begin
                total_cnt++; if ({Cout, S} !== 9'h100) $display("FAIL hold_in_run: Cout,S=%h required 100", {Cout, S}); else pass_cnt++;
            end
            if (k == 2) begin start = 1'b1; A = 8'h01; B = 8'h01; end
            if (k == 3) A = 8'h55;
            if (k == 4) begin start = 1'b0; A = 8'hAA; B = 8'h33; Cin = 1'b0; end
            @(negedge clk);
        end
        total_cnt++; if ({Cout, S} !== 9'h1FF) $display("FAIL ignore_sum: Cout,S=%h required 1FF", {Cout, S}); else pass_cnt++;
        total_cnt++; if (dn !== 1 || dk !== 9 || bn !== 8) $display("FAIL ignore_hs: done=%0d at=%0d busy=%0d required 1 at 9, 8", dn, dk, bn); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int bn, bl, dn, dk;
        launch(8'h7E, 8'h12, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: busy=%b required 0", busy); else pass_cnt++;
        observe(10, bn, bl, dn, dk);
        total_cnt++; if (dn !== 0 || bn !== 0) $display("FAIL abort_done: done=%0d busy=%0d required 0/0", dn, bn); else pass_cnt++;
        total_cnt++; if ({Cout, S} !== 9'h000) $display("FAIL abort_res: Cout,S=%h required 000", {Cout, S}); else pass_cnt++;
        @(negedge clk);
        launch(8'h10, 8'h20, 1'b0);
        observe(12, bn, bl, dn, dk);
        total_cnt++; if ({Cout, S} !== 9'h030 || dn !== 1) $display("FAIL after_abort: Cout,S=%h done=%0d required 030, 1", {Cout, S}, dn); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bn, bl, dn, dk;
        launch(8'h80, 8'h80, 1'b0);
        repeat (8) @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done1: done=%b required 1", done); else pass_cnt++;
        total_cnt++; if ({Cout, S} !== 9'h100) $display("FAIL b2b_sum1: Cout,S=%h required 100", {Cout, S}); else pass_cnt++;
        launch(8'h01, 8'h02, 1'b1);
        total_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_nogap: busy,done=%b%b required 10", busy, done); else pass_cnt++;
        observe(12, bn, bl, dn, dk);
        total_cnt++; if (dn !== 1 || dk !== 9) $display("FAIL b2b_spacing: done=%0d at=%0d required 1 at 9", dn, dk); else pass_cnt++;
        total_cnt++; if ({Cout, S} !== 9'h004) $display("FAIL b2b_sum2: Cout,S=%h required 004", {Cout, S}); else pass_cnt++;
        @(negedge clk);
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry_ripple();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
